// File: rtl/instruction_decode_stage.sv
// ID stage of a 5-stage MIPS-like pipeline: register file, decoder, hazard detection,
// early branch/jump resolution and the ID/EX pipeline register.
module instruction_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        flush_if_id,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dst,
  output logic [2:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        illegal_instr
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;
  localparam logic [5:0] FnNor = 6'h27;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;
  localparam logic [2:0] AluSlt = 3'd4;
  localparam logic [2:0] AluNor = 3'd5;

  // Instruction fields
  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;

  assign w_opcode   = instr_in[31:26];
  assign w_rs       = instr_in[25:21];
  assign w_rt       = instr_in[20:16];
  assign w_rd       = instr_in[15:11];
  assign w_funct    = instr_in[5:0];
  assign w_imm_sext = {{16{instr_in[15]}}, instr_in[15:0]};
  assign w_imm_zext = {16'h0000, instr_in[15:0]};

  // Decoder
  logic       w_issue;
  logic       w_illegal;
  logic       w_rtype;
  logic       w_reads_rs;
  logic       w_reads_rt;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_alu_src;
  logic       w_zero_ext;
  logic       w_is_beq;
  logic       w_is_bne;
  logic       w_is_j;
  logic [2:0] w_alu_op;
  logic [4:0] w_dst;

  always_comb begin
    w_issue     = 1'b0;
    w_illegal   = 1'b0;
    w_rtype     = 1'b0;
    w_reads_rs  = 1'b0;
    w_reads_rt  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_alu_src   = 1'b0;
    w_zero_ext  = 1'b0;
    w_is_beq    = 1'b0;
    w_is_bne    = 1'b0;
    w_is_j      = 1'b0;
    w_alu_op    = AluAdd;
    unique case (w_opcode)
      OpRtype: begin
        unique case (w_funct)
          FnAdd:   begin w_issue = 1'b1; w_alu_op = AluAdd; end
          FnSub:   begin w_issue = 1'b1; w_alu_op = AluSub; end
          FnAnd:   begin w_issue = 1'b1; w_alu_op = AluAnd; end
          FnOr:    begin w_issue = 1'b1; w_alu_op = AluOr;  end
          FnSlt:   begin w_issue = 1'b1; w_alu_op = AluSlt; end
          FnNor:   begin w_issue = 1'b1; w_alu_op = AluNor; end
          default: w_issue = 1'b0;
        endcase
        // funct 0 (all-zero word, shifts) is a silent NOP; other unknown functs are illegal
        if (w_issue) begin
          w_rtype     = 1'b1;
          w_reads_rs  = 1'b1;
          w_reads_rt  = 1'b1;
          w_reg_write = 1'b1;
        end else begin
          w_illegal = (w_funct != 6'h00);
        end
      end
      OpAddi: begin
        w_issue = 1'b1; w_reads_rs = 1'b1; w_reg_write = 1'b1; w_alu_src = 1'b1;
      end
      OpAndi: begin
        w_issue = 1'b1; w_reads_rs = 1'b1; w_reg_write = 1'b1; w_alu_src = 1'b1;
        w_zero_ext = 1'b1; w_alu_op = AluAnd;
      end
      OpOri: begin
        w_issue = 1'b1; w_reads_rs = 1'b1; w_reg_write = 1'b1; w_alu_src = 1'b1;
        w_zero_ext = 1'b1; w_alu_op = AluOr;
      end
      OpLw: begin
        w_issue = 1'b1; w_reads_rs = 1'b1; w_reg_write = 1'b1; w_alu_src = 1'b1;
        w_mem_read = 1'b1;
      end
      OpSw: begin
        w_issue = 1'b1; w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_alu_src = 1'b1;
        w_mem_write = 1'b1;
      end
      OpBeq: begin
        w_issue = 1'b1; w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_is_beq = 1'b1;
      end
      OpBne: begin
        w_issue = 1'b1; w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_is_bne = 1'b1;
      end
      OpJ: begin
        w_issue = 1'b1; w_is_j = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_dst = 5'd0;
    if (w_reg_write) begin
      w_dst = w_rtype ? w_rd : w_rt;
    end
  end

  // Register file with write-first bypass from WB
  logic [31:0] r_rf [32];
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rf <= '{default: '0};
    end else if (wb_en && (wb_addr != 5'd0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    w_rs_data = '0;
    w_rt_data = '0;
    if (w_rs != 5'd0) begin
      w_rs_data = (wb_en && (wb_addr == w_rs)) ? wb_data : r_rf[w_rs];
    end
    if (w_rt != 5'd0) begin
      w_rt_data = (wb_en && (wb_addr == w_rt)) ? wb_data : r_rf[w_rt];
    end
  end

  // Issue history: P1 is in EX, P2 is in MEM
  logic [4:0] r_p1_dst;
  logic       r_p1_reg_write;
  logic       r_p1_mem_read;
  logic [4:0] r_p2_dst;
  logic       r_p2_reg_write;
  logic       r_p2_mem_read;

  logic w_load_use;
  logic w_br_hazard;
  logic w_rs_pending;
  logic w_rt_pending;
  logic w_stall;

  assign w_load_use = r_p1_mem_read && (r_p1_dst != 5'd0) &&
                      ((w_reads_rs && (r_p1_dst == w_rs)) || (w_reads_rt && (r_p1_dst == w_rt)));

  // Branches resolve here, so any in-flight producer of an operand must drain to WB first
  assign w_rs_pending = (w_rs != 5'd0) && ((r_p1_reg_write && (r_p1_dst == w_rs)) ||
                                           (r_p2_reg_write && (r_p2_dst == w_rs)));
  assign w_rt_pending = (w_rt != 5'd0) && ((r_p1_reg_write && (r_p1_dst == w_rt)) ||
                                           (r_p2_reg_write && (r_p2_dst == w_rt)));
  assign w_br_hazard  = (w_is_beq || w_is_bne) && (w_rs_pending || w_rt_pending);
  assign w_stall      = w_load_use || w_br_hazard;

  // Branch / jump redirect
  logic        w_operands_eq;
  logic        w_taken;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;

  assign w_operands_eq   = (w_rs_data == w_rt_data);
  assign w_taken         = (w_is_beq && w_operands_eq) || (w_is_bne && !w_operands_eq);
  assign w_branch_target = pc_in + {w_imm_sext[29:0], 2'b00};
  assign w_jump_target   = {pc_in[31:28], instr_in[25:0], 2'b00};

  assign stall       = reset && w_stall;
  assign pc_load     = reset && !w_stall && (w_taken || w_is_j);
  assign flush_if_id = pc_load;

  always_comb begin
    pc_target = '0;
    if (pc_load) begin
      pc_target = w_is_j ? w_jump_target : w_branch_target;
    end
  end

  // ID/EX pipeline register
  logic [31:0] r_ex_rs_data;
  logic [31:0] r_ex_rt_data;
  logic [31:0] r_ex_imm;
  logic [4:0]  r_ex_rs;
  logic [4:0]  r_ex_rt;
  logic [4:0]  r_ex_dst;
  logic [2:0]  r_ex_alu_op;
  logic        r_ex_alu_src;
  logic        r_ex_reg_write;
  logic        r_ex_mem_read;
  logic        r_ex_mem_write;
  logic        r_ex_mem_to_reg;
  logic        r_illegal;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_rs_data    <= '0;
      r_ex_rt_data    <= '0;
      r_ex_imm        <= '0;
      r_ex_rs         <= '0;
      r_ex_rt         <= '0;
      r_ex_dst        <= '0;
      r_ex_alu_op     <= '0;
      r_ex_alu_src    <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_illegal       <= 1'b0;
      r_p1_dst        <= '0;
      r_p1_reg_write  <= 1'b0;
      r_p1_mem_read   <= 1'b0;
      r_p2_dst        <= '0;
      r_p2_reg_write  <= 1'b0;
      r_p2_mem_read   <= 1'b0;
    end else begin
      r_p2_dst       <= r_p1_dst;
      r_p2_reg_write <= r_p1_reg_write;
      r_p2_mem_read  <= r_p1_mem_read;
      r_illegal      <= w_illegal && !w_stall;
      if (w_stall || !w_issue) begin
        // Bubble: stalls, NOPs and undecodable words
        r_ex_rs_data    <= '0;
        r_ex_rt_data    <= '0;
        r_ex_imm        <= '0;
        r_ex_rs         <= '0;
        r_ex_rt         <= '0;
        r_ex_dst        <= '0;
        r_ex_alu_op     <= '0;
        r_ex_alu_src    <= 1'b0;
        r_ex_reg_write  <= 1'b0;
        r_ex_mem_read   <= 1'b0;
        r_ex_mem_write  <= 1'b0;
        r_ex_mem_to_reg <= 1'b0;
        r_p1_dst        <= '0;
        r_p1_reg_write  <= 1'b0;
        r_p1_mem_read   <= 1'b0;
      end else begin
        r_ex_rs_data    <= w_rs_data;
        r_ex_rt_data    <= w_rt_data;
        r_ex_imm        <= w_zero_ext ? w_imm_zext : w_imm_sext;
        r_ex_rs         <= w_rs;
        r_ex_rt         <= w_rt;
        r_ex_dst        <= w_dst;
        r_ex_alu_op     <= w_alu_op;
        r_ex_alu_src    <= w_alu_src;
        r_ex_reg_write  <= w_reg_write;
        r_ex_mem_read   <= w_mem_read;
        r_ex_mem_write  <= w_mem_write;
        r_ex_mem_to_reg <= w_mem_read;
        r_p1_dst        <= w_dst;
        r_p1_reg_write  <= w_reg_write;
        r_p1_mem_read   <= w_mem_read;
      end
    end
  end

  // P2 load flag is kept for completeness of the history; no current hazard rule reads it
  logic w_unused_p2;
  assign w_unused_p2 = r_p2_mem_read;

  assign ex_rs_data    = r_ex_rs_data;
  assign ex_rt_data    = r_ex_rt_data;
  assign ex_imm        = r_ex_imm;
  assign ex_rs         = r_ex_rs;
  assign ex_rt         = r_ex_rt;
  assign ex_dst        = r_ex_dst;
  assign ex_alu_op     = r_ex_alu_op;
  assign ex_alu_src    = r_ex_alu_src;
  assign ex_reg_write  = r_ex_reg_write;
  assign ex_mem_read   = r_ex_mem_read;
  assign ex_mem_write  = r_ex_mem_write;
  assign ex_mem_to_reg = r_ex_mem_to_reg;
  assign illegal_instr = r_illegal;

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset (reset=0 sampled at clk edge resets).
REQ-003 SHALL have ports instr_in (input, 32, IF/ID instruction) and pc_in (input, 32, IF/ID PC+4 of that instruction).
REQ-004 SHALL have ports wb_en (input, 1), wb_addr (input, 5), wb_data (input, 32): register-file write port from WB.
REQ-005 SHALL have hazard/redirect outputs: stall (1, hold PC and IF/ID), pc_load (1), pc_target (32), flush_if_id (1).
REQ-006 SHALL have registered ID/EX outputs: ex_rs_data, ex_rt_data, ex_imm (32 each), ex_rs, ex_rt, ex_dst (5 each), ex_alu_op (3), ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg (1 each).
REQ-007 SHALL have output illegal_instr, 1, registered one-cycle pulse for an undecodable instruction.

Function
REQ-008 SHALL contain a 32x32 register file; register 0 reads 0 and ignores writes.
REQ-009 SHALL bypass WB write-first: read of wb_addr (non-zero) with wb_en=1 in the same cycle returns wb_data.
REQ-010 SHALL decode: R-type (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, nor 0x27), addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
REQ-011 SHALL encode ex_alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 NOR; lw/sw/addi use ADD.
REQ-012 SHALL sign-extend imm for addi/lw/sw/beq/bne and zero-extend for andi/ori.
REQ-013 SHALL set ex_dst = rd for R-type, rt for I-type writers; 0 with ex_reg_write=0 for sw/beq/bne/j.
REQ-014 SHALL treat instr 0x00000000 and R-type with unlisted funct (other than 0) as NOP; unlisted funct or opcode additionally pulses illegal_instr next cycle.
REQ-015 SHALL track destinations of the instructions issued in the previous two cycles (P1 = in EX, P2 = in MEM), each with reg_write and mem_read flags; bubbles record dst 0.
REQ-016 SHALL assert stall (combinational) on load-use: P1 is a load, P1.dst != 0, and P1.dst equals rs, or rt for instructions that read rt.
REQ-017 SHALL assert stall for beq/bne when rs or rt (non-zero) equals P1.dst or P2.dst with reg_write set.
REQ-018 SHALL, while stall=1, load a bubble into ID/EX (all control outputs 0, ex_dst 0) and suppress pc_load/flush_if_id.
REQ-019 SHALL, for beq/bne without stall, compare operand values in the same cycle; if taken, assert pc_load=1, flush_if_id=1, pc_target = pc_in + (sign-extended imm << 2) modulo 2^32.
REQ-020 SHALL, for j, assert pc_load=1, flush_if_id=1, pc_target = {pc_in[31:28], instr_in[25:0], 2'b00}.
REQ-021 SHALL pass branch/jump into ID/EX with all control outputs 0 (no write, no memory access).
REQ-022 SHALL give stall priority over pc_load when both conditions would apply.
REQ-023 SHALL have ID/EX latency of exactly one cycle from instr_in to ex_* outputs.

Reset
REQ-024 SHALL, on reset=0 at a clk edge, clear all ex_* outputs, illegal_instr, P1, P2 to 0; register file contents also cleared to 0.
REQ-025 SHALL, during reset, drive stall=0, pc_load=0, flush_if_id=0 regardless of instr_in.
REQ-026 SHALL, on reset mid-stall, release stall the cycle reset is applied and discard pending history.

Verification
REQ-027 SHALL verify: wb write r5=0x1234 then add r3,r5,r0 -> next cycle ex_rs_data=0x1234, ex_dst=3, ex_alu_op=0, ex_reg_write=1.
REQ-028 SHALL verify: lw r2,0(r1) then add r4,r2,r2 -> stall=1 one cycle, ID/EX bubble, then add issues with ex_rs=2.
REQ-029 SHALL verify: beq r1,r1,+3 at pc_in=0x20 -> pc_load=1, flush_if_id=1, pc_target=0x2C; ex_reg_write=0.
REQ-030 SHALL verify: addi r6,r0,5 then beq r6,r0 -> stall two cycles, then not-taken, pc_load=0.
REQ-031 SHALL verify: j 0x40 with pc_in=0x10000004 -> pc_target=0x10000100; opcode 0x3F -> illegal_instr pulse, NOP issued.
REQ-032 SHALL verify: reset=0 asserted during a load-use stall -> next cycle all outputs 0, stall=0.
